lif_layer: RTL and testbench

//  Downstream consumer of the synaptic weight memory: one fully connected layer of N_OUT

---
 rtl/snn_pkg.sv | 34 +++
 rtl/lif_neuron.sv | 44 ++++
 rtl/lif_layer.sv | 123 ++++++++++++
 tb/tb_lif_layer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types, defaults and arithmetic helpers for the LIF spiking layer.
package snn_pkg;

    localparam int unsigned DEF_N_IN      = 16;
    localparam int unsigned DEF_N_OUT     = 8;
    localparam int unsigned DEF_POT_W     = 8;
    localparam int unsigned DEF_THRESHOLD = 4;
    localparam int unsigned DEF_LEAK      = 1;

    // Helpers work on a wide container so any POT_W up to 32 bits can reuse them.
    localparam int unsigned CALC_W = 32;

    typedef logic [DEF_POT_W-1:0] potential_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIRE = 2'd2,
        HOLD = 2'd3
    } lif_state_e;

    // Increment by one, clamping at vmax instead of wrapping.
    function automatic logic [CALC_W-1:0] sat_inc(input logic [CALC_W-1:0] v,
                                                  input logic [CALC_W-1:0] vmax);
        return (v >= vmax) ? vmax : v + CALC_W'(1);
    endfunction

    // Subtract d, flooring at zero.
    function automatic logic [CALC_W-1:0] floor_sub(input logic [CALC_W-1:0] v,
                                                    input logic [CALC_W-1:0] d);
        return (v >= d) ? v - d : '0;
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: saturating integration, leak, threshold and fire-reset.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int unsigned POT_W     = DEF_POT_W,
    parameter int unsigned THRESHOLD = DEF_THRESHOLD,
    parameter int unsigned LEAK      = DEF_LEAK
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             leak_fire,
    input  logic             clear,
    output logic             spike,
    output logic [POT_W-1:0] v
);

    localparam logic [POT_W-1:0] V_MAX = '1;

    logic [POT_W-1:0] r_v;
    logic [POT_W-1:0] w_inc_v;
    logic [POT_W-1:0] w_leak_v;

    assign w_inc_v  = POT_W'(sat_inc(CALC_W'(r_v), CALC_W'(V_MAX)));
    assign w_leak_v = POT_W'(floor_sub(CALC_W'(r_v), CALC_W'(LEAK)));

    // Fire decision is taken on the post-leak potential; only sampled during FIRE.
    assign spike = (CALC_W'(w_leak_v) >= CALC_W'(THRESHOLD));
    assign v     = r_v;

    // Potential register: clear beats fire/leak, which beats integration.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v <= '0;
        end else if (clear) begin
            r_v <= '0;
        end else if (leak_fire) begin
            r_v <= spike ? '0 : w_leak_v;
        end else if (inc) begin
            r_v <= w_inc_v;
        end
    end

endmodule

// File: rtl/lif_layer.sv
// Fully connected LIF layer: scans the 1-bit weight memory row by row per timestep.
module lif_layer
    import snn_pkg::*;
#(
    parameter int unsigned N_IN      = DEF_N_IN,
    parameter int unsigned N_OUT     = DEF_N_OUT,
    parameter int unsigned POT_W     = DEF_POT_W,
    parameter int unsigned THRESHOLD = DEF_THRESHOLD,
    parameter int unsigned LEAK      = DEF_LEAK
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN-1:0]         in_spikes,
    output logic [$clog2(N_IN)-1:0] w_raddr,
    input  logic [N_OUT-1:0]        w_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_OUT-1:0]        out_spikes,
    output logic                    busy,
    input  logic                    clear
);

    localparam int unsigned      IDX_W    = $clog2(N_IN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    lif_state_e r_state, w_nxt_state;
    logic [IDX_W-1:0] r_idx, w_nxt_idx;
    logic [N_IN-1:0]  r_spk_q, w_nxt_spk_q;
    logic [N_OUT-1:0] r_out_spikes, w_nxt_out_spikes;
    logic             r_out_valid, w_nxt_out_valid;
    logic             w_scan, w_fire, w_clear;
    logic             w_row_active;
    logic [N_OUT-1:0] w_spike;
    logic [N_OUT-1:0][POT_W-1:0] w_pot_unused;

    assign in_ready     = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign w_raddr      = w_scan ? r_idx : '0;
    assign out_valid    = r_out_valid;
    assign out_spikes   = r_out_spikes;
    assign w_row_active = w_scan & r_spk_q[r_idx];

    // Neuron array; row j of the current weight word feeds neuron j.
    for (genvar j = 0; j < int'(N_OUT); j++) begin : g_neuron
        lif_neuron #(
            .POT_W     (POT_W),
            .THRESHOLD (THRESHOLD),
            .LEAK      (LEAK)
        ) u_neuron (
            .clock     (clock),
            .reset_n   (reset_n),
            .inc       (w_row_active & w_rdata[j]),
            .leak_fire (w_fire),
            .clear     (w_clear),
            .spike     (w_spike[j]),
            .v         (w_pot_unused[j])
        );
    end

    // Next-state and control decode for IDLE -> SCAN -> FIRE -> HOLD.
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_idx        = r_idx;
        w_nxt_spk_q      = r_spk_q;
        w_nxt_out_spikes = r_out_spikes;
        w_nxt_out_valid  = r_out_valid;
        w_scan           = 1'b0;
        w_fire           = 1'b0;
        w_clear          = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear = clear;
                if (in_valid) begin
                    w_nxt_spk_q = in_spikes;
                    w_nxt_idx   = '0;
                    w_nxt_state = SCAN;
                end
            end
            SCAN: begin
                w_scan = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_nxt_idx   = '0;
                    w_nxt_state = FIRE;
                end else begin
                    w_nxt_idx = r_idx + IDX_W'(1);
                end
            end
            FIRE: begin
                w_fire           = 1'b1;
                w_nxt_out_spikes = w_spike;
                w_nxt_out_valid  = 1'b1;
                w_nxt_state      = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    w_nxt_out_valid = 1'b0;
                    w_nxt_state     = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // State, scan index, latched input vector and output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_spk_q      <= '0;
            r_out_spikes <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_idx        <= w_nxt_idx;
            r_spk_q      <= w_nxt_spk_q;
            r_out_spikes <= w_nxt_out_spikes;
            r_out_valid  <= w_nxt_out_valid;
        end
    end

endmodule

// File: tb/tb_lif_layer.sv
// Directed self-checking bench for lif_layer (default and saturating configurations).
module tb_lif_layer;

    logic        clock;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy, clear;
    logic [15:0] in_spikes;
    logic [3:0]  w_raddr;
    logic [7:0]  w_rdata, out_spikes;
    logic [7:0]  mem [16];

    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2, clear2;
    logic [15:0] in_spikes2;
    logic [3:0]  w_raddr2;
    logic [7:0]  w_rdata2, out_spikes2;

    int n_pass  = 0;
    int n_total = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign w_rdata  = mem[w_raddr];
    assign w_rdata2 = 8'hFF;

    lif_layer dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_spikes(in_spikes), .w_raddr(w_raddr), .w_rdata(w_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_spikes(out_spikes),
        .busy(busy), .clear(clear)
    );

    lif_layer #(.POT_W(4), .THRESHOLD(15), .LEAK(0)) dut2 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_spikes(in_spikes2), .w_raddr(w_raddr2), .w_rdata(w_rdata2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_spikes(out_spikes2),
        .busy(busy2), .clear(clear2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_mem(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] rest);
        for (int i = 0; i < 16; i++) mem[i] = rest;
        mem[0] = r0;
        mem[1] = r1;
    endtask

    // One timestep: accept, wait (bounded) for out_valid, complete handshake if out_ready.
    task automatic run_step(input logic [15:0] spk, input logic clr,
                            output logic [7:0] res, output int lat);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        in_valid  = 1'b1;
        in_spikes = spk;
        clear     = clr;
        tick();
        in_valid = 1'b0;
        clear    = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = out_spikes;
        if (out_ready) tick();
    endtask

    logic [7:0] res;
    int         lat;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_spikes = '0; out_ready = 1'b1; clear = 1'b0;
        in_valid2 = 1'b0; in_spikes2 = '0; out_ready2 = 1'b1; clear2 = 1'b0;
        set_mem(8'hFF, 8'hFF, 8'hFF);
        tick(); tick();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_spikes", 32'(out_spikes), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_raddr", 32'(w_raddr), 32'h0);
        reset_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // All-ones memory, five input spikes: every neuron reaches 5, leaks to 4, fires
        run_step(16'h001F, 1'b0, res, lat);
        check("s1_spikes", 32'(res), 32'hFF);
        check("s1_latency", 32'(lat), 32'd17);
        check("s1_pot0_reset", 32'(dut.w_pot_unused[0]), 32'h0);
        check("s1_out_valid_drop", 32'(out_valid), 32'h0);
        check("s1_idle_raddr", 32'(w_raddr), 32'h0);

        // Zero potential with no input: leak floors at 0
        run_step(16'h0000, 1'b0, res, lat);
        check("s6_floor_spikes", 32'(res), 32'h00);
        check("s6_floor_pot7", 32'(dut.w_pot_unused[7]), 32'h0);

        // Two synapses onto neuron 0: +2 -1 per step, fires on step 4
        set_mem(8'h01, 8'h01, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            run_step(16'h0003, 1'b0, res, lat);
            check($sformatf("s2_step%0d_spikes", k), 32'(res), 32'h00);
            check($sformatf("s2_step%0d_pot0", k), 32'(dut.w_pot_unused[0]), 32'(k));
        end
        run_step(16'h0003, 1'b0, res, lat);
        check("s2_step4_spikes", 32'(res), 32'h01);
        check("s2_step4_pot0", 32'(dut.w_pot_unused[0]), 32'h0);

        // Clear in IDLE after two steps
        run_step(16'h0003, 1'b0, res, lat);
        run_step(16'h0003, 1'b0, res, lat);
        check("s6_pre_clear_pot0", 32'(dut.w_pot_unused[0]), 32'h2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("s6_clear_pot0", 32'(dut.w_pot_unused[0]), 32'h0);

        // Clear together with in_valid: clear first, vector still accepted
        run_step(16'h0003, 1'b0, res, lat);
        run_step(16'h0003, 1'b0, res, lat);
        run_step(16'h0003, 1'b1, res, lat);
        check("s6_clear_accept_spikes", 32'(res), 32'h00);
        check("s6_clear_accept_pot0", 32'(dut.w_pot_unused[0]), 32'h1);

        // Back-pressure in HOLD: output stable, new input and clear ignored
        set_mem(8'hFF, 8'hFF, 8'hFF);
        out_ready = 1'b0;
        run_step(16'h001F, 1'b0, res, lat);
        check("s4_spikes", 32'(res), 32'hFF);
        check("s4_latency", 32'(lat), 32'd17);
        in_valid = 1'b1; in_spikes = 16'hFFFF; clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s4_hold_valid", 32'(out_valid), 32'h1);
            check("s4_hold_spikes", 32'(out_spikes), 32'hFF);
            check("s4_hold_in_ready", 32'(in_ready), 32'h0);
            check("s4_hold_busy", 32'(busy), 32'h1);
        end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        tick();
        check("s4_release_valid", 32'(out_valid), 32'h0);
        check("s4_release_in_ready", 32'(in_ready), 32'h1);
        check("s4_release_pot0", 32'(dut.w_pot_unused[0]), 32'h0);

        // Reset in the middle of a scan
        in_valid = 1'b1; in_spikes = 16'h001F;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("s5_scan_raddr", 32'(w_raddr), 32'h7);
        check("s5_scan_pot3", 32'(dut.w_pot_unused[3]), 32'h5);
        reset_n = 1'b0;
        #1;
        check("s5_rst_busy", 32'(busy), 32'h0);
        check("s5_rst_raddr", 32'(w_raddr), 32'h0);
        check("s5_rst_pot3", 32'(dut.w_pot_unused[3]), 32'h0);
        tick();
        check("s5_rst_out_valid", 32'(out_valid), 32'h0);
        reset_n = 1'b1;
        tick();
        check("s5_post_in_ready", 32'(in_ready), 32'h1);
        run_step(16'h0003, 1'b0, res, lat);
        check("s5_partial_spikes", 32'(res), 32'h00);
        check("s5_partial_pot5", 32'(dut.w_pot_unused[5]), 32'h1);
        run_step(16'h001F, 1'b1, res, lat);
        check("s5_fresh_spikes", 32'(res), 32'hFF);
        check("s5_fresh_latency", 32'(lat), 32'd17);

        // Saturating configuration: 16 hits clamp at 15 and fire
        check("s3_in_ready", 32'(in_ready2), 32'h1);
        in_valid2 = 1'b1; in_spikes2 = 16'hFFFF;
        tick();
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 100) begin
            tick();
            lat++;
        end
        check("s3_spikes", 32'(out_spikes2), 32'hFF);
        check("s3_latency", 32'(lat), 32'd17);
        check("s3_busy", 32'(busy2), 32'h1);
        tick();
        check("s3_release_valid", 32'(out_valid2), 32'h0);
        check("s3_idle_raddr", 32'(w_raddr2), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
